// File: rtl/blink_pkg.sv
// Shared types for the blink watchdog: FSM states, fault codes and the
// saturating toggle-count helper.
package blink_pkg;

    localparam int unsigned TOG_BITS = 2;

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_RUN        = 2'd1,
        ST_FAULT      = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE         = 2'b00,
        FC_LED_MISMATCH = 2'b01,
        FC_TIMEOUT      = 2'b10,
        FC_DOUBLE_PULSE = 2'b11
    } fault_code_t;

    // Add one toggle to the window count, sticking at the top value.
    function automatic logic [TOG_BITS-1:0] tog_sat_inc(input logic [TOG_BITS-1:0] cnt,
                                                        input logic inc);
        logic [TOG_BITS-1:0] top;
        top = '1;
        if (inc && (cnt != top)) begin
            return cnt + TOG_BITS'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/blink_watchdog.sv
// Watchdog for an upstream blinker: expects exactly one led toggle per
// flg window, no back-to-back flg pulses and no flg gap of TIMEOUT cycles.
module blink_watchdog
    import blink_pkg::*;
#(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned CNTBITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               led_in,
    input  logic               flg_in,
    output logic               alive,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [CNTBITS-1:0] evt_cnt
);

    localparam int unsigned GAP_BITS = $clog2(TIMEOUT + 1);
    localparam logic [GAP_BITS-1:0] GAP_LIMIT = GAP_BITS'(TIMEOUT - 1);
    localparam logic [GAP_BITS-1:0] GAP_MAX   = '1;
    localparam logic [CNTBITS-1:0]  EVT_MAX   = '1;

    state_t              state_q, state_d;
    fault_code_t         code_d;
    logic [CNTBITS-1:0]  evt_d;
    logic [GAP_BITS-1:0] gap_q, gap_d;
    logic [TOG_BITS-1:0] tog_q, tog_d, tog_sum;
    logic                led_prev_q, flg_prev_q;
    logic                alive_d, fault_d;

    // Next-state and next-output logic; the window count includes this cycle's toggle.
    always_comb begin
        state_d = state_q;
        code_d  = fault_code_t'(fault_code);
        evt_d   = evt_cnt;
        gap_d   = gap_q;
        tog_sum = tog_sat_inc(tog_q, led_in ^ led_prev_q);
        tog_d   = tog_sum;

        case (state_q)
            ST_WAIT_FIRST: begin
                if (flg_in) begin
                    state_d = ST_RUN;
                    evt_d   = CNTBITS'(1);
                    gap_d   = '0;
                    tog_d   = '0;
                end
            end
            ST_RUN: begin
                if (flg_in) begin
                    tog_d = '0;
                    if (flg_prev_q) begin
                        state_d = ST_FAULT;
                        code_d  = FC_DOUBLE_PULSE;
                    end else if (tog_sum != TOG_BITS'(1)) begin
                        state_d = ST_FAULT;
                        code_d  = FC_LED_MISMATCH;
                    end else begin
                        evt_d = (evt_cnt == EVT_MAX) ? evt_cnt : evt_cnt + CNTBITS'(1);
                        gap_d = '0;
                    end
                end else begin
                    if (gap_q == GAP_LIMIT) begin
                        state_d = ST_FAULT;
                        code_d  = FC_TIMEOUT;
                    end
                    gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_BITS'(1);
                end
            end
            ST_FAULT: begin
                tog_d = tog_q;
            end
            default: begin
                state_d = ST_WAIT_FIRST;
            end
        endcase

        alive_d = (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_FIRST;
            alive      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            evt_cnt    <= '0;
            gap_q      <= '0;
            tog_q      <= '0;
            led_prev_q <= 1'b0;
            flg_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive      <= alive_d;
            fault      <= fault_d;
            fault_code <= code_d;
            evt_cnt    <= evt_d;
            gap_q      <= gap_d;
            tog_q      <= tog_d;
            led_prev_q <= led_in;
            flg_prev_q <= flg_in;
        end
    end

endmodule

// File: tb/tb_blink_watchdog.sv
// Directed scoreboard bench for blink_watchdog (TIMEOUT=8), with a
// CNTBITS=4 twin sharing the stimulus to cover counter saturation.
module tb_blink_watchdog;

    logic        clk;
    logic        rst;
    logic        led_in;
    logic        flg_in;
    logic        alive, fault;
    logic [1:0]  fault_code;
    logic [15:0] evt_cnt;
    logic        alive4, fault4;
    logic [1:0]  fault_code4;
    logic [3:0]  evt_cnt4;

    blink_watchdog #(.TIMEOUT(8), .CNTBITS(16)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .flg_in(flg_in),
        .alive(alive), .fault(fault), .fault_code(fault_code), .evt_cnt(evt_cnt)
    );

    blink_watchdog #(.TIMEOUT(8), .CNTBITS(4)) dut4 (
        .clk(clk), .rst(rst), .led_in(led_in), .flg_in(flg_in),
        .alive(alive4), .fault(fault4), .fault_code(fault_code4), .evt_cnt(evt_cnt4)
    );

    typedef struct {
        string       tag;
        logic        alive;
        logic        fault;
        logic [1:0]  code;
        logic [15:0] evt;
        logic [3:0]  evt4;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic lv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic a, input logic f,
                              input logic [1:0] c, input int e);
        exp_t x;
        x.tag   = tag;
        x.alive = a;
        x.fault = f;
        x.code  = c;
        x.evt   = 16'(e);
        x.evt4  = (e > 15) ? 4'd15 : 4'(e);
        sb.push_back(x);
    endtask

    task automatic check_sb();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, ".alive"}, 32'(alive), 32'(x.alive));
            chk({x.tag, ".fault"}, 32'(fault), 32'(x.fault));
            chk({x.tag, ".code"}, 32'(fault_code), 32'(x.code));
            chk({x.tag, ".evt"}, 32'(evt_cnt), 32'(x.evt));
            chk({x.tag, ".alive4"}, 32'(alive4), 32'(x.alive));
            chk({x.tag, ".fault4"}, 32'(fault4), 32'(x.fault));
            chk({x.tag, ".evt4"}, 32'(evt_cnt4), 32'(x.evt4));
        end
    endtask

    task automatic cyc(input logic f, input logic l);
        @(negedge clk);
        rst    = 1'b0;
        flg_in = f;
        led_in = l;
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst    = 1'b1;
        flg_in = 1'b0;
        led_in = 1'b0;
        lv     = 1'b0;
        expect_out(tag, 1'b0, 1'b0, 2'b00, 0);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    // One accepted pulse, a toggle the following cycle, then idle to a 6-cycle period.
    task automatic pulse(input int n);
        expect_out($sformatf("pulse%0d", n), 1'b1, 1'b0, 2'b00, n);
        cyc(1'b1, lv);
        lv = ~lv;
        cyc(1'b0, lv);
        repeat (3) cyc(1'b0, lv);
        expect_out($sformatf("gap%0d", n), 1'b1, 1'b0, 2'b00, n);
        cyc(1'b0, lv);
    endtask

    initial begin
        rst = 1'b1; flg_in = 1'b0; led_in = 1'b0; lv = 1'b0;

        // Normal operation: 10 well-formed pulses.
        do_reset("reset");
        expect_out("wait_first", 1'b0, 1'b0, 2'b00, 0);
        cyc(1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) pulse(i);

        // Timeout: fault appears exactly on the 8th flg-free edge.
        expect_out("pulse11", 1'b1, 1'b0, 2'b00, 11);
        cyc(1'b1, lv);
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) expect_out($sformatf("free%0d", i), 1'b1, 1'b0, 2'b00, 11);
            else       expect_out("timeout", 1'b0, 1'b1, 2'b10, 11);
            cyc(1'b0, lv);
        end
        expect_out("frozen_a", 1'b0, 1'b1, 2'b10, 11);
        cyc(1'b1, ~lv);
        cyc(1'b0, lv);
        expect_out("frozen_b", 1'b0, 1'b1, 2'b10, 11);
        cyc(1'b1, ~lv);

        // Reset out of FAULT, then long idle stays in WAIT_FIRST.
        do_reset("reset_from_fault");
        repeat (99) cyc(1'b0, 1'b0);
        expect_out("idle100", 1'b0, 1'b0, 2'b00, 0);
        cyc(1'b0, 1'b0);

        // No toggle between pulses.
        expect_out("nt_p1", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        expect_out("no_toggle", 1'b0, 1'b1, 2'b01, 1);
        cyc(1'b1, 1'b0);

        // Two toggles in one window.
        do_reset("reset_e");
        expect_out("tt_p1", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        expect_out("tt_mid", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b0, 1'b0);
        expect_out("two_toggles", 1'b0, 1'b1, 2'b01, 1);
        cyc(1'b1, 1'b0);

        // Toggle on the flg cycle itself counts toward that window.
        do_reset("reset_f");
        expect_out("tf_p1", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        expect_out("toggle_on_flg", 1'b1, 1'b0, 2'b00, 2);
        cyc(1'b1, 1'b1);

        // Double pulse with led mismatch: double pulse wins.
        do_reset("reset_g");
        expect_out("dp_p1", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        expect_out("dp_p2", 1'b1, 1'b0, 2'b00, 2);
        cyc(1'b1, 1'b1);
        expect_out("double_prio", 1'b0, 1'b1, 2'b11, 2);
        cyc(1'b1, 1'b1);

        // Back-to-back flg from WAIT_FIRST.
        do_reset("reset_h");
        cyc(1'b0, 1'b0);
        expect_out("wf_first", 1'b1, 1'b0, 2'b00, 1);
        cyc(1'b1, 1'b0);
        expect_out("wf_double", 1'b0, 1'b1, 2'b11, 1);
        cyc(1'b1, 1'b0);

        // 20 pulses: the 4-bit counter sticks at 15.
        do_reset("reset_i");
        for (int i = 1; i <= 20; i++) pulse(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
